ccd_bayer_capture: RTL
======================

Name: ccd_bayer_capture

Overview:
Parametrised successor to the camera capture/demosaic front end. Qualifies raw Bayer pixels from the sensor (iFVAL/iLVAL), tracks X/Y/frame counts and buffers one line. Emits one half-resolution RGB pixel per 2x2 Bayer quad, with a selectable CFA pattern and start/stop capture control. Sits between the sensor pins and the frame-buffer writer, entirely in the pixel clock domain.

Parameters:
DATA_W, 12, raw pixel and colour channel width
MAX_W, 1280, line buffer depth; maximum captured pixels per line
CNT_W, 16, width of X/Y counters
FRAME_W, 32, frame counter width
BAYER, 0, top-left quad colour: 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR

Ports:
iCLK  in  1  pixel clock; sole clock
iRST  in  1  reset: synchronous, active-high
iDATA  in  DATA_W  raw sensor pixel
iFVAL  in  1  frame valid from sensor
iLVAL  in  1  line valid from sensor
iSTART  in  1  pulse: arm capture
iEND  in  1  pulse: disarm capture
oRed  out  DATA_W  red channel
oGreen  out  DATA_W  green channel (average of two greens)
oBlue  out  DATA_W  blue channel
oDVAL  out  1  one-cycle strobe: RGB/oX/oY valid
oX_Cont  out  CNT_W  output pixel column (raw x >> 1)
oY_Cont  out  CNT_W  output pixel row (raw y >> 1)
oFrame_Cont  out  FRAME_W  completed captured frames
oBusy  out  1  a frame is being captured
oOVF  out  1  sticky: line exceeded MAX_W in the current frame

Behaviour:
- Reset: every output is 0; run=0, cap=0, counters=0. Line buffer contents are don't-care.
- iFVAL and iLVAL are registered once (fval_q, lval_q) for edge detection.
- run flag: iSTART sets it, iEND clears it. If both pulse in the same cycle, iEND wins.
- cap (drives oBusy):
  - Set on an iFVAL rising edge (iFVAL=1, fval_q=0) while run=1.
  - Cleared on an iFVAL falling edge.
  - iEND mid-frame does not clear cap; the current frame completes.
- Pixel qualifier pv = cap & iFVAL & iLVAL. cap is a register, so pixels in the FVAL-rising cycle itself are never captured.
- Raw x:
  - Increments on each pv cycle and saturates at MAX_W.
  - Resets to 0 on iLVAL falling edge and on frame start.
- Raw y:
  - Increments on iLVAL falling edge while cap=1.
  - Resets to 0 on frame start.
- Line buffer (depth MAX_W, width DATA_W):
  - On pv with x<MAX_W, write iDATA at address x.
  - Read at address x in the same cycle; the read returns the old (previous-line) data, registered with 1-cycle read latency.
- Overflow: a pv with x==MAX_W drops the pixel (no write, no output) and sets oOVF. oOVF clears on the next frame start.
- Demosaic pipeline:
  - Stage 1 (pv cycle): capture cur=iDATA; left = pixel from the previous pv cycle; read buffer at x and at x-1 (held from the previous cycle).
  - Stage 2: form quad TL=above(x-1), TR=above(x), BL=left, BR=cur. Map quad to R/G/B per BAYER.
  - Green = (G1+G2)>>1, summed at DATA_W+1 bits with no rounding.
- Output:
  - Produced only when the pv pixel has x odd and y odd.
  - oDVAL is high exactly 2 cycles after the edge sampling that pixel.
  - oX_Cont=x>>1 and oY_Cont=y>>1 are aligned with oDVAL.
  - RGB, oX_Cont and oY_Cont hold their values when oDVAL=0.
- oFrame_Cont increments (wrapping) on each iFVAL falling edge while cap=1.
- Reset mid-frame: everything returns to reset values, including run=0. Capture resumes only after a new iSTART and a new FVAL rising edge.
- Odd line width: the trailing pixel produces no output. Odd line count: the last row produces no output.

Test Plan:
- Reset, then iSTART, then a 4x4 frame with pixel value = 16*y+x, BAYER=0 -> 4 oDVAL pulses:
  - (0,0): R=0, G=(1+16)>>1=8, B=17
  - (1,0): R=2, G=10, B=19
  - (0,1): R=32, G=40, B=49
  - (1,1): R=34, G=42, B=51
  - oFrame_Cont=1.
- Same frame with BAYER=3 -> (0,0) gives R=17, B=0, G=8.
- No iSTART, frame sent -> no oDVAL, oBusy=0, oFrame_Cont=0. iSTART during iFVAL=1 -> capture begins only at the next FVAL rise.
- iEND mid-frame -> current frame finishes (4 outputs, count=1); next frame is ignored. iSTART and iEND in the same cycle -> run=0.
- MAX_W=4, line of 6 pixels -> oOVF=1 and only x<4 produce outputs; oOVF=0 after the next frame start.
- Latency: first qualifying pixel (x=1, y=1) sampled at cycle N -> oDVAL=1 at N+2 only. Assert iRST at N+1 -> oDVAL=0 and all outputs 0 at N+2.

Source files
------------

// File: rtl/ccd_bayer_capture.sv
// Camera capture / demosaic front end.
// Qualifies raw Bayer pixels with frame/line valid and keeps raw X/Y and
// frame counters. Buffers one line and emits one half-resolution RGB
// pixel per 2x2 Bayer quad, with start/stop capture control.
//
// Ports:
//   iCLK, iRST            pixel clock, synchronous active-high reset
//   iDATA                 raw sensor pixel
//   iFVAL, iLVAL          frame / line valid from the sensor
//   iSTART, iEND          arm / disarm capture pulses (iEND wins a tie)
//   oRed/oGreen/oBlue     demosaiced colour channels (held between strobes)
//   oDVAL                 one-cycle strobe qualifying RGB and oX/oY_Cont
//   oX_Cont, oY_Cont      output pixel column / row (raw x,y >> 1)
//   oFrame_Cont           completed captured frames
//   oBusy                 a frame is being captured
//   oOVF                  sticky: a line exceeded MAX_W in this frame
module ccd_bayer_capture #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned MAX_W   = 1280,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned FRAME_W = 32,
  parameter int unsigned BAYER   = 0
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [DATA_W-1:0]  iDATA,
  input  logic               iFVAL,
  input  logic               iLVAL,
  input  logic               iSTART,
  input  logic               iEND,
  output logic [DATA_W-1:0]  oRed,
  output logic [DATA_W-1:0]  oGreen,
  output logic [DATA_W-1:0]  oBlue,
  output logic               oDVAL,
  output logic [CNT_W-1:0]   oX_Cont,
  output logic [CNT_W-1:0]   oY_Cont,
  output logic [FRAME_W-1:0] oFrame_Cont,
  output logic               oBusy,
  output logic               oOVF
);

  localparam int unsigned AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] X_LIMIT = CNT_W'(MAX_W);

  logic              fval_q, lval_q, run, cap, ovf;
  logic [CNT_W-1:0]  x, y;
  logic [DATA_W-1:0] line_buf [MAX_W];

  // Stage 1: current, left, above(x), above(x-1)
  logic [DATA_W-1:0] s1_cur, s1_left, s1_up, s1_upl;
  logic              s1_vld;
  logic [CNT_W-1:0]  s1_x, s1_y;

  // Stage 2: quad mapped to colour planes
  logic [DATA_W-1:0] s2_r, s2_g1, s2_g2, s2_b;
  logic              s2_vld;
  logic [CNT_W-1:0]  s2_x, s2_y;

  logic [DATA_W-1:0] map_r_c, map_g1_c, map_g2_c, map_b_c;
  logic [DATA_W:0]   g_sum_c;

  logic fval_rise, fval_fall, lval_fall, frame_start, pv, wr, emit;

  assign fval_rise   = iFVAL & ~fval_q;
  assign fval_fall   = ~iFVAL & fval_q;
  assign lval_fall   = ~iLVAL & lval_q;
  assign frame_start = fval_rise & run;
  assign pv          = cap & iFVAL & iLVAL;
  assign wr          = pv & (x < X_LIMIT);
  // Only the bottom-right pixel of each quad completes an output
  assign emit        = wr & x[0] & y[0];

  assign oBusy = cap;
  assign oOVF  = ovf;

  // Line buffer: no reset, read-before-write gives the previous line
  always_ff @(posedge iCLK) begin
    if (wr) line_buf[x[AW-1:0]] <= iDATA;
  end

  // Map TL/TR/BL/BR of the quad to R, G, G, B for the chosen CFA
  always_comb begin
    map_r_c  = s1_upl;
    map_g1_c = s1_up;
    map_g2_c = s1_left;
    map_b_c  = s1_cur;
    case (BAYER)
      1: begin
        map_r_c = s1_up;   map_g1_c = s1_upl; map_g2_c = s1_cur;  map_b_c = s1_left;
      end
      2: begin
        map_r_c = s1_left; map_g1_c = s1_upl; map_g2_c = s1_cur;  map_b_c = s1_up;
      end
      3: begin
        map_r_c = s1_cur;  map_g1_c = s1_up;  map_g2_c = s1_left; map_b_c = s1_upl;
      end
      default: ;
    endcase
  end

  assign g_sum_c = {1'b0, s2_g1} + {1'b0, s2_g2};

  // Control, counters and demosaic pipeline
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      fval_q      <= 1'b0;
      lval_q      <= 1'b0;
      run         <= 1'b0;
      cap         <= 1'b0;
      ovf         <= 1'b0;
      x           <= '0;
      y           <= '0;
      oFrame_Cont <= '0;
      s1_cur      <= '0;
      s1_left     <= '0;
      s1_up       <= '0;
      s1_upl      <= '0;
      s1_vld      <= 1'b0;
      s1_x        <= '0;
      s1_y        <= '0;
      s2_r        <= '0;
      s2_g1       <= '0;
      s2_g2       <= '0;
      s2_b        <= '0;
      s2_vld      <= 1'b0;
      s2_x        <= '0;
      s2_y        <= '0;
      oRed        <= '0;
      oGreen      <= '0;
      oBlue       <= '0;
      oDVAL       <= 1'b0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
    end else begin
      fval_q <= iFVAL;
      lval_q <= iLVAL;

      if (iEND)        run <= 1'b0;
      else if (iSTART) run <= 1'b1;

      // iEND does not touch cap, so an armed frame always completes
      if (frame_start)    cap <= 1'b1;
      else if (fval_fall) cap <= 1'b0;

      if (fval_fall && cap) oFrame_Cont <= oFrame_Cont + FRAME_W'(1);

      if (frame_start || lval_fall) x <= '0;
      else if (pv && x != X_LIMIT)  x <= x + CNT_W'(1);

      if (frame_start)           y <= '0;
      else if (lval_fall && cap) y <= y + CNT_W'(1);

      if (frame_start)               ovf <= 1'b0;
      else if (pv && x == X_LIMIT)   ovf <= 1'b1;

      // Stage 1 advances only on stored pixels so left/above-left stay adjacent
      if (wr) begin
        s1_cur  <= iDATA;
        s1_left <= s1_cur;
        s1_up   <= line_buf[x[AW-1:0]];
        s1_upl  <= s1_up;
        s1_x    <= x >> 1;
        s1_y    <= y >> 1;
      end
      s1_vld <= emit;

      if (s1_vld) begin
        s2_r  <= map_r_c;
        s2_g1 <= map_g1_c;
        s2_g2 <= map_g2_c;
        s2_b  <= map_b_c;
        s2_x  <= s1_x;
        s2_y  <= s1_y;
      end
      s2_vld <= s1_vld;

      if (s2_vld) begin
        oRed    <= s2_r;
        oGreen  <= g_sum_c[DATA_W:1];
        oBlue   <= s2_b;
        oX_Cont <= s2_x;
        oY_Cont <= s2_y;
      end
      oDVAL <= s2_vld;
    end
  end

endmodule
